mmc_fifo_tx_sched: RTL and testbench

Write-side scheduler for the MMC transmit async FIFO. It shares the single FIFO write port between two requesters: the command engine (short fixed-length packets) and the sector data engine (fixed-length blocks). Each packet is framed with a header word and then streamed under FIFO full backpressure. The block also sequences FIFO abort/flush through the FIFO's write-side sync-reset input. It runs entirely in the FIFO write clock domain.

---
 rtl/mmc_fifo_pkg.sv | 10 +
 rtl/mmc_fifo_rr_arb2.sv | 21 ++
 rtl/mmc_fifo_tx_sched.sv | 92 +++++++++
 tb/tb_mmc_fifo_tx_sched.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/mmc_fifo_pkg.sv
// mmc_fifo_pkg: shared states, source ids, header layout and header builder for the MMC TX FIFO scheduler
package mmc_fifo_pkg;
  typedef enum logic [1:0] {S_IDLE, S_HDR, S_BODY, S_FLUSH} state_t;
  localparam logic SRC_CMD = 1'b0;
  localparam logic SRC_DAT = 1'b1;
  localparam int HDR_LEN_LSB = 0;
  function automatic logic [63:0] build_hdr(input logic sel, input logic [31:0] len, input int n);
    return {32'd0, len} << HDR_LEN_LSB | 64'(sel) << (n - 1);
  endfunction
endpackage

// File: rtl/mmc_fifo_rr_arb2.sv
// mmc_fifo_rr_arb2: two-way round-robin grant (cmd/dat); last-served moves only on packet completion
// ports: clk, rst_n, req_cmd, req_dat, done, done_src in; grant_valid, grant_src out
module mmc_fifo_rr_arb2
  import mmc_fifo_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic req_cmd,
  input  logic req_dat,
  input  logic done,
  input  logic done_src,
  output logic grant_valid,
  output logic grant_src
);
  logic last;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last <= SRC_DAT;
    else if (done) last <= done_src;
  assign grant_valid = req_cmd | req_dat;
  assign grant_src = (req_cmd && req_dat) ? ~last : req_dat;
endmodule

// File: rtl/mmc_fifo_tx_sched.sv
// mmc_fifo_tx_sched: shares the TX FIFO write port between command and data engines, frames packets, sequences abort/flush
// ports: iCLOCK/inRESET; cmd and dat valid/data/ready streams; iABORT; FIFO wr_en/wr_data/full/reset_sync; oBUSY, oDONE, oDONE_SRC
module mmc_fifo_tx_sched
  import mmc_fifo_pkg::*;
#(
  parameter int N = 16,
  parameter int CMD_WORDS = 3,
  parameter int BLK_WORDS = 256,
  parameter int LEN_N = 9,
  parameter int FLUSH_CYCLES = 4
) (
  input  logic         iCLOCK,
  input  logic         inRESET,
  input  logic         iCMD_VALID,
  input  logic [N-1:0] iCMD_DATA,
  output logic         oCMD_READY,
  input  logic         iDAT_VALID,
  input  logic [N-1:0] iDAT_DATA,
  output logic         oDAT_READY,
  input  logic         iABORT,
  output logic         oFIFO_WR_EN,
  output logic [N-1:0] oFIFO_WR_DATA,
  input  logic         iFIFO_WR_FULL,
  output logic         oFIFO_RESET_SYNC,
  output logic         oBUSY,
  output logic         oDONE,
  output logic         oDONE_SRC
);
  state_t state, state_nxt;
  logic sel, sel_nxt;
  logic [LEN_N-1:0] cnt, cnt_nxt, len;
  logic [N-1:0] hdr, src_data;
  logic grant_valid, grant_src, src_valid, hdr_wr, body_rdy, body_wr, last;
  mmc_fifo_rr_arb2 u_arb (
    .clk(iCLOCK), .rst_n(inRESET), .req_cmd(iCMD_VALID), .req_dat(iDAT_VALID),
    .done(last), .done_src(sel), .grant_valid(grant_valid), .grant_src(grant_src)
  );
  assign len = sel ? LEN_N'(BLK_WORDS) : LEN_N'(CMD_WORDS);
  assign hdr = N'(build_hdr(sel, 32'(len), N));
  assign src_valid = sel ? iDAT_VALID : iCMD_VALID;
  assign src_data = sel ? iDAT_DATA : iCMD_DATA;
  // abort suppresses every write and handshake in its cycle so the requester keeps the word
  assign hdr_wr = state == S_HDR && !iFIFO_WR_FULL && !iABORT;
  assign body_rdy = state == S_BODY && !iFIFO_WR_FULL && !iABORT;
  assign body_wr = body_rdy && src_valid;
  assign last = body_wr && cnt == LEN_N'(1);
  assign oCMD_READY = body_rdy && sel == SRC_CMD;
  assign oDAT_READY = body_rdy && sel == SRC_DAT;
  assign oFIFO_WR_EN = hdr_wr | body_wr;
  assign oFIFO_WR_DATA = hdr_wr ? hdr : body_wr ? src_data : '0;
  assign oBUSY = state != S_IDLE;
  assign oDONE = last;
  assign oDONE_SRC = last & sel;
  always_ff @(posedge iCLOCK or negedge inRESET)
    if (!inRESET) begin
      state <= S_IDLE;
      sel <= SRC_CMD;
      cnt <= '0;
      oFIFO_RESET_SYNC <= 1'b0;
    end else begin
      state <= state_nxt;
      sel <= sel_nxt;
      cnt <= cnt_nxt;
      oFIFO_RESET_SYNC <= iABORT;
    end
  // the word counter doubles as the flush timer while in FLUSH
  always_comb begin
    state_nxt = state;
    sel_nxt = sel;
    cnt_nxt = cnt;
    if (iABORT) begin
      state_nxt = S_FLUSH;
      cnt_nxt = LEN_N'(FLUSH_CYCLES - 1);
    end else
      case (state)
        S_IDLE: if (grant_valid) begin
          state_nxt = S_HDR;
          sel_nxt = grant_src;
          cnt_nxt = grant_src ? LEN_N'(BLK_WORDS) : LEN_N'(CMD_WORDS);
        end
        S_HDR: state_nxt = hdr_wr ? S_BODY : S_HDR;
        S_BODY: if (body_wr) begin
          cnt_nxt = cnt - LEN_N'(1);
          state_nxt = last ? S_IDLE : S_BODY;
        end
        default: begin
          state_nxt = cnt == '0 ? S_IDLE : S_FLUSH;
          cnt_nxt = cnt == '0 ? cnt : cnt - LEN_N'(1);
        end
      endcase
  end
endmodule

// File: tb/tb_mmc_fifo_tx_sched.sv
// tb_mmc_fifo_tx_sched: scoreboard bench; expected FIFO writes queued at stimulus time, monitor pops on every write
module tb_mmc_fifo_tx_sched;
  logic iCLOCK = 0, inRESET = 0;
  logic iCMD_VALID = 0, iDAT_VALID = 0, iABORT = 0, iFIFO_WR_FULL = 0;
  logic [15:0] iCMD_DATA = 0, iDAT_DATA = 0, oFIFO_WR_DATA;
  logic oCMD_READY, oDAT_READY, oFIFO_WR_EN, oFIFO_RESET_SYNC, oBUSY, oDONE, oDONE_SRC;
  always #5 iCLOCK = ~iCLOCK;
  mmc_fifo_tx_sched dut (
    .iCLOCK(iCLOCK), .inRESET(inRESET),
    .iCMD_VALID(iCMD_VALID), .iCMD_DATA(iCMD_DATA), .oCMD_READY(oCMD_READY),
    .iDAT_VALID(iDAT_VALID), .iDAT_DATA(iDAT_DATA), .oDAT_READY(oDAT_READY),
    .iABORT(iABORT), .oFIFO_WR_EN(oFIFO_WR_EN), .oFIFO_WR_DATA(oFIFO_WR_DATA),
    .iFIFO_WR_FULL(iFIFO_WR_FULL), .oFIFO_RESET_SYNC(oFIFO_RESET_SYNC),
    .oBUSY(oBUSY), .oDONE(oDONE), .oDONE_SRC(oDONE_SRC)
  );
  typedef struct {logic [15:0] d; logic done; logic src;} exp_t;
  exp_t sb[$];
  logic [15:0] cq[$], dq[$];
  int vectors = 0, miscompares = 0, cmd_sent = 0, dat_sent = 0;
  logic want_full = 0, s_we, s_dr, s_rs, s_busy, s_done;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  always @(negedge iCLOCK) begin
    #2;
    if (inRESET) begin
      if (oFIFO_WR_EN && iFIFO_WR_FULL) chk("wr_while_full", 1, 0);
      if (oFIFO_WR_EN) begin
        if (sb.size() == 0) chk("unexpected_write", {16'h0, oFIFO_WR_DATA}, 32'hFFFFFFFF);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("wr_data", {16'h0, oFIFO_WR_DATA}, {16'h0, e.d});
          chk("done", {31'h0, oDONE}, {31'h0, e.done});
          if (e.done) chk("done_src", {31'h0, oDONE_SRC}, {31'h0, e.src});
        end
      end else if (oDONE) chk("done_without_write", 1, 0);
    end
  end
  task automatic send(input logic src, input logic [15:0] base, input int n, input int n_exp);
    sb.push_back('{src ? 16'h8100 : 16'h0003, 1'b0, 1'b0});
    for (int i = 0; i < n; i++) if (src) dq.push_back(base + 16'(i)); else cq.push_back(base + 16'(i));
    for (int i = 0; i < n_exp; i++) sb.push_back('{base + 16'(i), i == n - 1, src});
  endtask
  task automatic cyc(input logic ab);
    logic cf, df;
    @(negedge iCLOCK);
    iABORT = ab;
    iFIFO_WR_FULL = want_full;
    iCMD_VALID = cq.size() != 0;
    iCMD_DATA = iCMD_VALID ? cq[0] : 16'h0;
    iDAT_VALID = dq.size() != 0;
    iDAT_DATA = iDAT_VALID ? dq[0] : 16'h0;
    #1;
    cf = iCMD_VALID && oCMD_READY;
    df = iDAT_VALID && oDAT_READY;
    s_we = oFIFO_WR_EN; s_dr = oDAT_READY; s_rs = oFIFO_RESET_SYNC; s_busy = oBUSY; s_done = oDONE;
    @(posedge iCLOCK);
    if (cf) begin void'(cq.pop_front()); cmd_sent++; end
    if (df) begin void'(dq.pop_front()); dat_sent++; end
  endtask
  task automatic run_all(input int max);
    for (int i = 0; i < max; i++) begin
      if (cq.size() == 0 && dq.size() == 0 && sb.size() == 0) break;
      cyc(0);
    end
    chk("drain", sb.size() + cq.size() + dq.size(), 0);
  endtask
  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_wr_en"}, {31'h0, oFIFO_WR_EN}, 0);
    chk({tag, "_wr_data"}, {16'h0, oFIFO_WR_DATA}, 0);
    chk({tag, "_busy"}, {31'h0, oBUSY}, 0);
    chk({tag, "_done"}, {31'h0, oDONE}, 0);
    chk({tag, "_done_src"}, {31'h0, oDONE_SRC}, 0);
    chk({tag, "_rsync"}, {31'h0, oFIFO_RESET_SYNC}, 0);
    chk({tag, "_cmd_ready"}, {31'h0, oCMD_READY}, 0);
    chk({tag, "_dat_ready"}, {31'h0, oDAT_READY}, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
  initial begin
    logic stalled;
    repeat (3) @(posedge iCLOCK);
    #1 chk_idle_outputs("reset");
    @(negedge iCLOCK) inRESET = 1;
    send(0, 16'h00A0, 3, 3);
    repeat (5) cyc(0);
    chk("t1_four_consecutive", sb.size(), 0);
    cyc(0);
    chk("t1_idle_after", {31'h0, s_busy}, 0);
    @(negedge iCLOCK) inRESET = 0;
    @(negedge iCLOCK) inRESET = 1;
    send(0, 16'h0100, 3, 3);
    send(1, 16'h1000, 256, 256);
    dat_sent = 0; stalled = 0;
    for (int i = 0; i < 600; i++) begin
      if (cq.size() == 0 && dq.size() == 0 && sb.size() == 0) break;
      if (!stalled && dat_sent == 10) begin
        want_full = 1;
        repeat (5) begin
          cyc(0);
          chk("t3_ready_stalled", {31'h0, s_dr}, 0);
          chk("t3_wr_stalled", {31'h0, s_we}, 0);
        end
        want_full = 0;
        cyc(0);
        chk("t3_word11_on_release", dat_sent, 11);
        stalled = 1;
      end else cyc(0);
    end
    chk("t3_drain", sb.size() + dq.size(), 0);
    send(0, 16'h0200, 3, 3);
    send(1, 16'h2000, 256, 99);
    dat_sent = 0;
    for (int i = 0; i < 400; i++) begin
      if (dat_sent == 99) begin
        cyc(1);
        chk("t4_abort_no_write", {31'h0, s_we}, 0);
        break;
      end
      cyc(0);
    end
    dq.delete();
    for (int i = 0; i < 5; i++) begin
      cyc(0);
      chk("t4_rsync", {31'h0, s_rs}, {31'h0, i == 0});
      chk("t4_busy", {31'h0, s_busy}, {31'h0, i < 4});
      chk("t4_no_done", {31'h0, s_done}, 0);
    end
    chk("t4_sb_empty", sb.size(), 0);
    send(1, 16'h3000, 256, 256);
    send(0, 16'h0300, 3, 3);
    run_all(700);
    send(0, 16'h0400, 3, 2);
    cmd_sent = 0;
    for (int i = 0; i < 20; i++) begin
      if (cmd_sent == 2) begin
        cyc(1);
        chk("t5_last_not_written", {31'h0, s_we}, 0);
        chk("t5_no_done", {31'h0, s_done}, 0);
        break;
      end
      cyc(0);
    end
    cq.delete();
    cyc(0);
    chk("t5_flush_busy", {31'h0, s_busy}, 1);
    chk("t5_rsync", {31'h0, s_rs}, 1);
    repeat (4) cyc(0);
    chk("t5_back_idle", {31'h0, s_busy}, 0);
    chk("t5_sb_empty", sb.size(), 0);
    cq.push_back(16'h0ABC); cq.push_back(16'h0ABD); cq.push_back(16'h0ABE);
    cyc(1);
    cq.delete();
    cyc(0);
    chk("t6_idle_abort_rsync", {31'h0, s_rs}, 1);
    chk("t6_no_grant_write", {31'h0, s_we}, 0);
    repeat (4) cyc(0);
    chk("t6_back_idle", {31'h0, s_busy}, 0);
    send(0, 16'h0600, 3, 3);
    run_all(20);
    cq.push_back(16'h0777); cq.push_back(16'h0778); cq.push_back(16'h0779);
    cyc(0);
    @(negedge iCLOCK);
    inRESET = 0;
    iCMD_VALID = 0;
    #1 chk_idle_outputs("t7_async_reset");
    cq.delete();
    @(negedge iCLOCK) inRESET = 1;
    send(0, 16'h0800, 3, 3);
    send(1, 16'h8000, 256, 256);
    run_all(700);
    repeat (2) cyc(0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
